interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 32 +++
 rtl/interrupt_controller_sync_edge.sv | 33 +++
 rtl/interrupt_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared peripheral definitions for the interrupt controller: register map,
// source limit, claim word layout and small bus helpers.
package interrupt_controller_pkg;

  localparam int MAX_SOURCES = 31;

  localparam logic [7:0] OFF_RAW     = 8'h00;
  localparam logic [7:0] OFF_ENABLE  = 8'h04;
  localparam logic [7:0] OFF_MODE    = 8'h08;
  localparam logic [7:0] OFF_PENDING = 8'h0C;
  localparam logic [7:0] OFF_ACTIVE  = 8'h10;
  localparam logic [7:0] OFF_CLAIM   = 8'h14;
  localparam logic [7:0] OFF_CTRL    = 8'h18;

  typedef struct packed {
    logic        valid;
    logic [25:0] rsvd;
    logic [4:0]  id;
  } claim_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = '0;
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{be[i]}};
  endfunction

  // Lowest set bit wins; 0 when nothing is set.
  function automatic logic [4:0] lowest_idx(input logic [31:0] v);
    lowest_idx = '0;
    for (int i = 31; i >= 0; i--) if (v[i]) lowest_idx = 5'(i);
  endfunction

endpackage

// File: rtl/interrupt_controller_sync_edge.sv
// Per-source two-flop synchronizer plus a prev flop for rising-edge detection.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic level,
  output logic rise
);
  logic       sync1, sync2, prev, armed;
  logic [1:0] vld_pipe;

  // An edge needs a genuine 0 seen in sync2 after it settles, so a source
  // already high when reset releases never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      armed    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync1    <= irq;
      sync2    <= sync1;
      prev     <= sync2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      armed    <= armed | (vld_pipe[1] & ~sync2);
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~prev & armed;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: per-source edge/level pending, enable
// mask, lowest-index claim and a registered irq line to the core.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [7:0] ID      = 8'h04,
  parameter int         SOURCES = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               peripheralBus_we,
  input  logic               peripheralBus_oe,
  output logic               peripheralBus_busy,
  input  logic [23:0]        peripheralBus_address,
  input  logic [3:0]         peripheralBus_byteSelect,
  input  logic [31:0]        peripheralBus_dataWrite,
  output logic [31:0]        peripheralBus_dataRead,
  output logic               requestOutput,
  input  logic [SOURCES-1:0] peripheral_irq,
  output logic               irq_o,
  output logic [4:0]         irq_id_o
);

  if (SOURCES > MAX_SOURCES || SOURCES < 1) begin : g_bad_sources
    $error("interrupt_controller: SOURCES out of range");
  end

  logic               sel, wr, rd, claim_rd, claim_fire, claim_q, ctrl_en, any_active;
  logic [7:0]         off;
  logic [31:0]        wmask, rdata;
  logic [4:0]         low_idx;
  logic [SOURCES-1:0] wm, wd, level, rise, enable_q, mode_q, mode_nxt, mode_chg;
  logic [SOURCES-1:0] pending_q, pending_nxt, active, w1c, claim_clr;
  claim_t             claim;
  logic               unused;

  for (genvar i = 0; i < SOURCES; i++) begin : g_src
    irq_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .irq   (peripheral_irq[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  assign sel      = peripheralBus_address[23:16] == ID;
  assign off      = peripheralBus_address[7:0];
  assign wr       = sel & peripheralBus_we;
  assign rd       = sel & peripheralBus_oe;
  assign wmask    = lane_mask(peripheralBus_byteSelect);
  assign wm       = wmask[SOURCES-1:0];
  assign wd       = peripheralBus_dataWrite[SOURCES-1:0];
  assign unused   = ^{peripheralBus_address[15:8], peripheralBus_dataWrite, wmask};

  assign active     = pending_q & enable_q;
  assign any_active = |active;
  assign low_idx    = lowest_idx(32'(active));
  assign claim      = '{valid: any_active, rsvd: '0, id: low_idx};

  // Claim only on the first cycle of a CLAIM read; a held oe does not re-claim.
  assign claim_rd   = rd & (off == OFF_CLAIM);
  assign claim_fire = claim_rd & ~claim_q;
  assign claim_clr  = (claim_fire && any_active) ? SOURCES'(32'h1 << low_idx) : '0;
  assign w1c        = (wr && off == OFF_PENDING) ? (wd & wm) : '0;

  assign mode_nxt = (wr && off == OFF_MODE) ? ((mode_q & ~wm) | (wd & wm)) : mode_q;
  assign mode_chg = mode_nxt ^ mode_q;

  // Edge set beats a same-cycle clear; level sources just follow sync2.
  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (mode_chg[i])    pending_nxt[i] = 1'b0;
      else if (mode_q[i]) pending_nxt[i] = rise[i] | (pending_q[i] & ~(w1c[i] | claim_clr[i]));
      else                pending_nxt[i] = level[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      ctrl_en   <= 1'b0;
      claim_q   <= 1'b0;
      irq_o     <= 1'b0;
      irq_id_o  <= '0;
    end else begin
      if (wr && off == OFF_ENABLE) enable_q <= (enable_q & ~wm) | (wd & wm);
      if (wr && off == OFF_CTRL && peripheralBus_byteSelect[0])
        ctrl_en <= peripheralBus_dataWrite[0];
      mode_q    <= mode_nxt;
      pending_q <= pending_nxt;
      claim_q   <= claim_rd;
      irq_o     <= ctrl_en & any_active;
      irq_id_o  <= low_idx;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_RAW:     rdata = 32'(level);
      OFF_ENABLE:  rdata = 32'(enable_q);
      OFF_MODE:    rdata = 32'(mode_q);
      OFF_PENDING: rdata = 32'(pending_q);
      OFF_ACTIVE:  rdata = 32'(active);
      OFF_CLAIM:   rdata = claim;
      OFF_CTRL:    rdata = {31'b0, ctrl_en};
      default:     rdata = '0;
    endcase
  end

  assign peripheralBus_dataRead = sel ? rdata : '1;
  assign requestOutput          = rd;
  assign peripheralBus_busy     = 1'b0;

endmodule
